// File: rtl/clock_pkg.sv
// Shared mode encoding, field limits and timing constants for the hour/minute setup path.
package clock_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        CLK_HOUR = 3'd1,
        CLK_MIN  = 3'd2,
        ALM_HOUR = 3'd3,
        ALM_MIN  = 3'd4
    } state_e;

    localparam int unsigned HOUR_MAX_C       = 23;
    localparam int unsigned MINUTE_MAX_C     = 59;
    localparam int unsigned CYCLES_PER_SEC_C = 62_500_000;

    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max_v);
        return (v >= max_v) ? 7'd0 : v + 7'd1;
    endfunction

endpackage

// File: rtl/btn_release_edge.sv
// Release detector for one level button: pulses when the last sample was 1 and the current is 0.
module btn_release_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rel_o
);

    logic last_q;

    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b0;
        else       last_q <= btn_i;
    end

    assign rel_o = last_q & ~btn_i;

endmodule

// File: rtl/time_set_controller.sv
// Button-driven time/alarm edit sequencer; alarm edit and match logic exist only with TIME_SET_ALARM_EN.
// state    | meaning
// RUN      | normal display, buttons only enter edit
// CLK_HOUR | editing clock hour
// CLK_MIN  | editing clock minute, mode commits via load_time
// ALM_HOUR | editing alarm hour
// ALM_MIN  | editing alarm minute, mode commits alarm registers
module time_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 10 * CYCLES_PER_SEC_C,
    parameter int unsigned HOUR_MAX       = HOUR_MAX_C,
    parameter int unsigned MINUTE_MAX     = MINUTE_MAX_C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic [6:0] cur_hour,
    input  logic [6:0] cur_minute,
    output state_e     state,
    output logic [6:0] edit_hour,
    output logic [6:0] edit_minute,
    output logic       load_time,
    output logic [6:0] alarm_hour,
    output logic [6:0] alarm_minute,
    output logic       alarm_enable,
    output logic       alarm_fire
);

    localparam logic [29:0] TIMEOUT_C    = 30'(TIMEOUT_CYCLES);
    localparam logic [6:0]  HOUR_MAX_L   = 7'(HOUR_MAX);
    localparam logic [6:0]  MINUTE_MAX_L = 7'(MINUTE_MAX);

    state_e      state_q, state_d;
    logic [6:0]  edit_hour_q, edit_hour_d, edit_minute_q, edit_minute_d;
    logic        load_q, load_d;
    logic [29:0] cnt_q, cnt_d;
    logic        mode_rel, up_rel, edit_busy;

    btn_release_edge u_mode_rel (.clk(clk), .reset(reset), .btn_i(btn_mode), .rel_o(mode_rel));
    btn_release_edge u_up_rel   (.clk(clk), .reset(reset), .btn_i(btn_up),   .rel_o(up_rel));

`ifdef TIME_SET_ALARM_EN
    logic [6:0] alarm_hour_q, alarm_hour_d, alarm_minute_q, alarm_minute_d;
    logic       alarm_en_q, alarm_en_d;
    logic [1:0] preload_q, preload_d;
    logic       match, match_prev_q, fire_q;

    assign edit_busy = |preload_q;
`else
    assign edit_busy = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        edit_hour_d   = edit_hour_q;
        edit_minute_d = edit_minute_q;
        load_d        = 1'b0;
        cnt_d         = cnt_q;
`ifdef TIME_SET_ALARM_EN
        alarm_hour_d   = alarm_hour_q;
        alarm_minute_d = alarm_minute_q;
        alarm_en_d     = alarm_en_q;
        preload_d      = {preload_q[0], 1'b0};
        // Alarm preload lands two edges after load_time so the timekeeper sees stable edit values.
        if (preload_q[1]) begin
            edit_hour_d   = alarm_hour_q;
            edit_minute_d = alarm_minute_q;
        end
`endif
        if (state_q == RUN) begin
            cnt_d = '0;
            if (mode_rel) begin
                state_d       = CLK_HOUR;
                edit_hour_d   = cur_hour;
                edit_minute_d = cur_minute;
                cnt_d         = TIMEOUT_C;
            end
        end else if (mode_rel) begin
            cnt_d = TIMEOUT_C;
            unique case (state_q)
                CLK_HOUR: state_d = CLK_MIN;
                CLK_MIN: begin
                    load_d = 1'b1;
`ifdef TIME_SET_ALARM_EN
                    state_d   = ALM_HOUR;
                    preload_d = 2'b01;
`else
                    state_d = RUN;
                    cnt_d   = '0;
`endif
                end
                ALM_HOUR: state_d = ALM_MIN;
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
`ifdef TIME_SET_ALARM_EN
                    alarm_hour_d   = edit_hour_q;
                    alarm_minute_d = edit_minute_q;
                    alarm_en_d     = 1'b1;
`endif
                end
            endcase
        end else if (up_rel) begin
            cnt_d = TIMEOUT_C;
            if (!edit_busy) begin
                if (state_q == CLK_HOUR || state_q == ALM_HOUR)
                    edit_hour_d = wrap_inc(edit_hour_q, HOUR_MAX_L);
                else
                    edit_minute_d = wrap_inc(edit_minute_q, MINUTE_MAX_L);
            end
        end else if (cnt_q <= 30'd1) begin
            state_d = RUN;
            cnt_d   = '0;
`ifdef TIME_SET_ALARM_EN
            preload_d = 2'b00;
`endif
        end else begin
            cnt_d = cnt_q - 30'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            edit_hour_q   <= '0;
            edit_minute_q <= '0;
            load_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            edit_hour_q   <= edit_hour_d;
            edit_minute_q <= edit_minute_d;
            load_q        <= load_d;
            cnt_q         <= cnt_d;
        end
    end

`ifdef TIME_SET_ALARM_EN
    assign match = alarm_en_q && ({cur_hour, cur_minute} == {alarm_hour_q, alarm_minute_q});

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_hour_q   <= '0;
            alarm_minute_q <= '0;
            alarm_en_q     <= 1'b0;
            preload_q      <= '0;
            match_prev_q   <= 1'b0;
            fire_q         <= 1'b0;
        end else begin
            alarm_hour_q   <= alarm_hour_d;
            alarm_minute_q <= alarm_minute_d;
            alarm_en_q     <= alarm_en_d;
            preload_q      <= preload_d;
            match_prev_q   <= match;
            fire_q         <= match & ~match_prev_q;
        end
    end

    assign alarm_hour   = alarm_hour_q;
    assign alarm_minute = alarm_minute_q;
    assign alarm_enable = alarm_en_q;
    assign alarm_fire   = fire_q;
`else
    assign alarm_hour   = '0;
    assign alarm_minute = '0;
    assign alarm_enable = 1'b0;
    assign alarm_fire   = 1'b0;
`endif

    assign state       = state_q;
    assign edit_hour   = edit_hour_q;
    assign edit_minute = edit_minute_q;
    assign load_time   = load_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller: stimulus queues expected snapshots and load strobes, a negedge monitor checks them.
module tb_time_set_controller;
    import clock_pkg::*;

    localparam int unsigned TO = 50;

    logic       clk = 1'b0, reset = 1'b1, btn_mode = 1'b0, btn_up = 1'b0;
    logic [6:0] cur_hour = 7'd14, cur_minute = 7'd37;
    state_e     state;
    logic [6:0] edit_hour, edit_minute, alarm_hour, alarm_minute;
    logic       load_time, alarm_enable, alarm_fire;

    int cyc = 0, tests = 0, fails = 0, fire_cnt = 0;

    typedef struct {
        int         due;
        string      name;
        logic [2:0] st;
        logic [6:0] eh, em, ah, am;
        logic       ae, lt;
    } snap_t;

    snap_t       snap_q[$];
    logic [13:0] load_q[$];
    logic [6:0]  exp_ah = 7'd0, exp_am = 7'd0;
    logic        exp_ae = 1'b0;

    time_set_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .state(state),
        .edit_hour(edit_hour), .edit_minute(edit_minute), .load_time(load_time),
        .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
        .alarm_enable(alarm_enable), .alarm_fire(alarm_fire)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops due snapshots and expected load strobes.
    always @(negedge clk) begin
        snap_t s;
        logic [13:0] e;
        while (snap_q.size() > 0 && snap_q[0].due <= cyc) begin
            s = snap_q.pop_front();
            chk({s.name, ".state"},        int'(state),        int'(s.st));
            chk({s.name, ".edit_hour"},    int'(edit_hour),    int'(s.eh));
            chk({s.name, ".edit_minute"},  int'(edit_minute),  int'(s.em));
            chk({s.name, ".load_time"},    int'(load_time),    int'(s.lt));
            chk({s.name, ".alarm_hour"},   int'(alarm_hour),   int'(s.ah));
            chk({s.name, ".alarm_minute"}, int'(alarm_minute), int'(s.am));
            chk({s.name, ".alarm_enable"}, int'(alarm_enable), int'(s.ae));
        end
        if (load_time) begin
            if (load_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_load: load_time high with edit %0d:%0d, none expected", edit_hour, edit_minute);
            end else begin
                e = load_q.pop_front();
                chk("load_hour",   int'(edit_hour),   int'(e[13:7]));
                chk("load_minute", int'(edit_minute), int'(e[6:0]));
            end
        end
        if (alarm_fire) fire_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Button(s) high for one edge, low at the next: the release acts on that second edge.
    task automatic rel(input logic m, input logic u);
        btn_mode = m;
        btn_up   = u;
        tick(1);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        tick(1);
    endtask

    task automatic expect_snap(input string nm, input state_e st, input int eh, input int em,
                               input logic lt, input int offs);
        snap_t s;
        s.due  = cyc + offs;
        s.name = nm;
        s.st   = st;
        s.eh   = 7'(eh);
        s.em   = 7'(em);
        s.lt   = lt;
        s.ah   = exp_ah;
        s.am   = exp_am;
        s.ae   = exp_ae;
        snap_q.push_back(s);
    endtask

    initial begin
        int fire_base;
        int exp_fire;

        tick(3);
        expect_snap("in_reset", RUN, 0, 0, 1'b0, 0);
        reset = 1'b0;
        tick(1);
        expect_snap("post_reset", RUN, 0, 0, 1'b0, 0);

        rel(1'b0, 1'b1);
        expect_snap("up_in_run", RUN, 0, 0, 1'b0, 0);
        rel(1'b1, 1'b0);
        expect_snap("enter_clk_hour", CLK_HOUR, 14, 37, 1'b0, 0);
        repeat (9) rel(1'b0, 1'b1);
        expect_snap("hour_23", CLK_HOUR, 23, 37, 1'b0, 0);
        rel(1'b0, 1'b1);
        expect_snap("hour_wrap", CLK_HOUR, 0, 37, 1'b0, 0);
        rel(1'b1, 1'b1);
        expect_snap("mode_wins", CLK_MIN, 0, 37, 1'b0, 0);
        repeat (22) rel(1'b0, 1'b1);
        expect_snap("minute_59", CLK_MIN, 0, 59, 1'b0, 0);
        rel(1'b0, 1'b1);
        expect_snap("minute_wrap", CLK_MIN, 0, 0, 1'b0, 0);
        reset = 1'b1;
        tick(1);
        expect_snap("reset_mid_edit", RUN, 0, 0, 1'b0, 0);
        reset = 1'b0;
        tick(1);

        // Full pass: clock 08:15, then alarm 06:30 where present.
        rel(1'b1, 1'b0);
        expect_snap("pass_clk_hour", CLK_HOUR, 14, 37, 1'b0, 0);
        repeat (18) rel(1'b0, 1'b1);
        expect_snap("pass_hour_8", CLK_HOUR, 8, 37, 1'b0, 0);
        rel(1'b1, 1'b0);
        expect_snap("pass_clk_min", CLK_MIN, 8, 37, 1'b0, 0);
        repeat (38) rel(1'b0, 1'b1);
        expect_snap("pass_min_15", CLK_MIN, 8, 15, 1'b0, 0);
        load_q.push_back({7'd8, 7'd15});
        rel(1'b1, 1'b0);
`ifdef TIME_SET_ALARM_EN
        expect_snap("load_strobe", ALM_HOUR, 8, 15, 1'b1, 0);
        tick(1);
        expect_snap("load_hold", ALM_HOUR, 8, 15, 1'b0, 0);
        tick(1);
        expect_snap("alarm_preload", ALM_HOUR, 0, 0, 1'b0, 0);
        repeat (6) rel(1'b0, 1'b1);
        expect_snap("alm_hour_6", ALM_HOUR, 6, 0, 1'b0, 0);
        rel(1'b1, 1'b0);
        expect_snap("alm_min", ALM_MIN, 6, 0, 1'b0, 0);
        repeat (30) rel(1'b0, 1'b1);
        expect_snap("alm_min_30", ALM_MIN, 6, 30, 1'b0, 0);
        exp_ah = 7'd6;
        exp_am = 7'd30;
        exp_ae = 1'b1;
        rel(1'b1, 1'b0);
        expect_snap("alarm_commit", RUN, 6, 30, 1'b0, 0);
        exp_fire = 1;
`else
        expect_snap("load_strobe", RUN, 8, 15, 1'b1, 0);
        tick(1);
        expect_snap("load_hold", RUN, 8, 15, 1'b0, 0);
        exp_fire = 0;
`endif
        tick(2);

        // Timeout restarts on every button release.
        rel(1'b1, 1'b0);
        expect_snap("to_enter", CLK_HOUR, 14, 37, 1'b0, 0);
        tick(29);
        rel(1'b0, 1'b1);
        expect_snap("to_reload", CLK_HOUR, 15, 37, 1'b0, 0);
        expect_snap("to_last_edit_cycle", CLK_HOUR, 15, 37, 1'b0, TO - 1);
        expect_snap("to_expired", RUN, 15, 37, 1'b0, TO);
        tick(TO + 2);

`ifdef TIME_SET_ALARM_EN
        rel(1'b1, 1'b0);
        rel(1'b1, 1'b0);
        expect_snap("alm_to_clk_min", CLK_MIN, 14, 37, 1'b0, 0);
        load_q.push_back({7'd14, 7'd37});
        rel(1'b1, 1'b0);
        expect_snap("alm_to_enter", ALM_HOUR, 14, 37, 1'b1, 0);
        expect_snap("alm_to_last", ALM_HOUR, 6, 30, 1'b0, TO - 1);
        expect_snap("alm_to_expired", RUN, 6, 30, 1'b0, TO);
        tick(TO + 2);
`endif

        // Alarm match: 06:29 -> 06:30 held for 100 cycles.
        cur_hour   = 7'd6;
        cur_minute = 7'd29;
        tick(5);
        fire_base  = fire_cnt;
        cur_minute = 7'd30;
        tick(100);
        chk("alarm_fire_count", fire_cnt - fire_base, exp_fire);

        tick(2);
        chk("snapshots_drained", snap_q.size(), 0);
        chk("loads_drained", load_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
